// File: rtl/bsg_mem_init_pkg.sv
// Types shared by the self-initialising 1rw bit-mask memory and its storage array.
package bsg_mem_init_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/bsg_mem_1rw_bit_mask_array.sv
// Synchronous single-port storage with per-bit write mask and registered read.
// Holds no reset so it can be replaced by a hardened macro with the same ports.
module bsg_mem_1rw_bit_mask_array #(
    parameter int width_p       = 15,
    parameter int els_p         = 64,
    parameter int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] r_mem [els_p];
    logic [width_p-1:0] r_data;

    // Read register only moves on a read, so it holds the last value read.
    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            for (int i = 0; i < width_p; i++) begin
                if (w_mask_i[i]) begin
                    r_mem[addr_i][i] <= data_i[i];
                end
            end
        end
        if (v_i && !w_i) begin
            r_data <= r_mem[addr_i];
        end
    end

    assign data_o = r_data;

endmodule

// File: rtl/bsg_mem_1rw_bit_mask_init.sv
// 1rw bit-masked memory that sweeps init_val_p into every word after reset,
// then serves one read or write per cycle with 1-cycle read latency.
module bsg_mem_1rw_bit_mask_init
    import bsg_mem_init_pkg::*;
#(
    parameter int                 width_p       = 15,
    parameter int                 els_p         = 64,
    parameter logic [width_p-1:0] init_val_p    = '0,
    parameter int                 addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,
    output logic                     ready_o,
    output logic                     init_done_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o
);

    localparam logic [addr_width_lp-1:0] cnt_last_lp  = addr_width_lp'(els_p - 1);
    localparam logic [addr_width_lp:0]   addr_limit_lp = (addr_width_lp + 1)'(els_p);

    state_e                   r_state;
    logic [addr_width_lp-1:0] r_cnt;
    logic                     r_v_o;
    logic                     r_has_data;
    logic                     r_oob;

    logic                     w_ready;
    logic                     w_in_range;
    logic                     w_accept;
    logic                     w_rd_accept;
    logic                     w_arr_v;
    logic                     w_arr_w;
    logic [addr_width_lp-1:0] w_arr_addr;
    logic [width_p-1:0]       w_arr_data;
    logic [width_p-1:0]       w_arr_mask;
    logic [width_p-1:0]       w_rd_data;

    assign w_ready     = (r_state == READY);
    assign w_in_range  = ({1'b0, addr_i} < addr_limit_lp);
    assign w_accept    = v_i && w_ready;
    assign w_rd_accept = w_accept && !w_i;

    // The sweep owns the array port until READY; user requests are ignored then.
    always_comb begin
        w_arr_v    = 1'b1;
        w_arr_w    = 1'b1;
        w_arr_addr = r_cnt;
        w_arr_data = init_val_p;
        w_arr_mask = '1;
        if (w_ready) begin
            w_arr_v    = w_accept && w_in_range;
            w_arr_w    = w_i;
            w_arr_addr = addr_i;
            w_arr_data = data_i;
            w_arr_mask = w_mask_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= INIT;
            r_cnt      <= '0;
            r_v_o      <= 1'b0;
            r_has_data <= 1'b0;
            r_oob      <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_cnt == cnt_last_lp) begin
                        r_state <= READY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + addr_width_lp'(1);
                    end
                end
                READY:   r_state <= READY;
                default: r_state <= INIT;
            endcase
            r_v_o <= w_rd_accept;
            if (w_rd_accept) begin
                r_has_data <= 1'b1;
                r_oob      <= !w_in_range;
            end
        end
    end

    bsg_mem_1rw_bit_mask_array #(
        .width_p       (width_p),
        .els_p         (els_p),
        .addr_width_lp (addr_width_lp)
    ) u_array (
        .clk_i    (clk_i),
        .v_i      (w_arr_v),
        .w_i      (w_arr_w),
        .addr_i   (w_arr_addr),
        .data_i   (w_arr_data),
        .w_mask_i (w_arr_mask),
        .data_o   (w_rd_data)
    );

    // Gating keeps data_o at zero after reset and for out-of-range reads,
    // since the array's read register itself is never reset.
    assign ready_o     = w_ready;
    assign init_done_o = w_ready;
    assign v_o         = r_v_o;
    assign data_o      = (r_has_data && !r_oob) ? w_rd_data : '0;

endmodule

// File: tb/tb_bsg_mem_1rw_bit_mask_init.sv
// Directed bench: a 64-word and a 40-word instance, both initialised to 0x1234.
module tb_bsg_mem_1rw_bit_mask_init;

    logic        clk;
    logic        rst_n, v, w;
    logic [5:0]  addr;
    logic [14:0] data, mask;
    logic        ready, done, vo;
    logic [14:0] dout;

    logic        rst2_n, v2, w2;
    logic [5:0]  addr2;
    logic [14:0] data2, mask2;
    logic        ready2, done2, vo2;
    logic [14:0] dout2;

    int tests  = 0;
    int failed = 0;

    bsg_mem_1rw_bit_mask_init #(
        .width_p    (15),
        .els_p      (64),
        .init_val_p (15'h1234)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .v_i         (v),
        .w_i         (w),
        .addr_i      (addr),
        .data_i      (data),
        .w_mask_i    (mask),
        .ready_o     (ready),
        .init_done_o (done),
        .v_o         (vo),
        .data_o      (dout)
    );

    bsg_mem_1rw_bit_mask_init #(
        .width_p    (15),
        .els_p      (40),
        .init_val_p (15'h1234)
    ) dut40 (
        .clk_i       (clk),
        .reset_n_i   (rst2_n),
        .v_i         (v2),
        .w_i         (w2),
        .addr_i      (addr2),
        .data_i      (data2),
        .w_mask_i    (mask2),
        .ready_o     (ready2),
        .init_done_o (done2),
        .v_o         (vo2),
        .data_o      (dout2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus helpers: drive one request, advance one edge, sample 1 time unit later.
    task automatic drive_read(input logic [5:0] a);
        v = 1'b1; w = 1'b0; addr = a;
        @(posedge clk); #1;
        v = 1'b0;
    endtask

    task automatic drive_write(input logic [5:0] a, input logic [14:0] d, input logic [14:0] m);
        v = 1'b1; w = 1'b1; addr = a; data = d; mask = m;
        @(posedge clk); #1;
        v = 1'b0;
    endtask

    task automatic drive_read2(input logic [5:0] a);
        v2 = 1'b1; w2 = 1'b0; addr2 = a;
        @(posedge clk); #1;
        v2 = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (ready !== 1'b0 || done !== 1'b0 || vo !== 1'b0 || dout !== 15'h0) begin
            failed++;
            $display("FAIL reset_values: ready=%b done=%b v_o=%b data_o=%h, expected 0 0 0 0000",
                     ready, done, vo, dout);
        end
        // Writes held during the sweep must be dropped.
        v = 1'b1; w = 1'b1; addr = 6'd0; data = 15'h7FFF; mask = 15'h7FFF;
        rst_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        v = 1'b0;
        tests++;
        if (n != 64) begin
            failed++;
            $display("FAIL sweep_length: ready_o rose after %0d cycles, expected 64", n);
        end
        tests++;
        if (done !== 1'b1 || vo !== 1'b0) begin
            failed++;
            $display("FAIL init_done: done=%b v_o=%b, expected 1 0", done, vo);
        end
        $display("[TB] reset released, ready after %0d cycles", n);
    endtask

    task automatic test_init_sweep;
        for (int a = 0; a < 64; a++) begin
            drive_read(6'(a));
            tests++;
            if (vo !== 1'b1 || dout !== 15'h1234) begin
                failed++;
                $display("FAIL init_read addr=%0d: v_o=%b data_o=%h, expected 1 1234", a, vo, dout);
            end
        end
        $display("[TB] init sweep read-back of 64 words done");
    endtask

    task automatic test_masked_write;
        drive_write(6'd5, 15'h7FFF, 15'h00FF);
        tests++;
        if (vo !== 1'b0 || dout !== 15'h1234) begin
            failed++;
            $display("FAIL write_no_vo: v_o=%b data_o=%h, expected 0 1234", vo, dout);
        end
        drive_read(6'd5);
        tests++;
        if (vo !== 1'b1 || dout !== 15'h12FF) begin
            failed++;
            $display("FAIL masked_write: v_o=%b data_o=%h, expected 1 12ff", vo, dout);
        end
        $display("[TB] masked write addr 5 -> %h", dout);
    endtask

    task automatic test_back_to_back;
        drive_read(6'd5);
        tests++;
        if (vo !== 1'b1 || dout !== 15'h12FF) begin
            failed++;
            $display("FAIL b2b_read: v_o=%b data_o=%h, expected 1 12ff", vo, dout);
        end
        drive_write(6'd5, 15'h0000, 15'h7FFF);
        tests++;
        if (vo !== 1'b0 || dout !== 15'h12FF) begin
            failed++;
            $display("FAIL b2b_write_hold: v_o=%b data_o=%h, expected 0 12ff", vo, dout);
        end
        @(posedge clk); #1;
        tests++;
        if (vo !== 1'b0 || dout !== 15'h12FF) begin
            failed++;
            $display("FAIL idle_hold: v_o=%b data_o=%h, expected 0 12ff", vo, dout);
        end
        drive_read(6'd5);
        tests++;
        if (vo !== 1'b1 || dout !== 15'h0000) begin
            failed++;
            $display("FAIL b2b_reread: v_o=%b data_o=%h, expected 1 0000", vo, dout);
        end
        // Zero mask is a no-op.
        drive_write(6'd5, 15'h7FFF, 15'h0000);
        drive_read(6'd5);
        tests++;
        if (vo !== 1'b1 || dout !== 15'h0000) begin
            failed++;
            $display("FAIL zero_mask: v_o=%b data_o=%h, expected 1 0000", vo, dout);
        end
        drive_read(6'd0);
        tests++;
        if (vo !== 1'b1 || dout !== 15'h1234) begin
            failed++;
            $display("FAIL init_write_dropped: v_o=%b data_o=%h, expected 1 1234", vo, dout);
        end
        $display("[TB] back-to-back read/write on addr 5 done");
    endtask

    task automatic test_out_of_range;
        int n;
        rst2_n = 1'b1;
        n = 0;
        while (ready2 !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n != 40) begin
            failed++;
            $display("FAIL sweep40_length: ready_o rose after %0d cycles, expected 40", n);
        end
        drive_read2(6'd3);
        tests++;
        if (vo2 !== 1'b1 || dout2 !== 15'h1234) begin
            failed++;
            $display("FAIL els40_read3: v_o=%b data_o=%h, expected 1 1234", vo2, dout2);
        end
        drive_read2(6'd45);
        tests++;
        if (vo2 !== 1'b1 || dout2 !== 15'h0000) begin
            failed++;
            $display("FAIL oob_read: v_o=%b data_o=%h, expected 1 0000", vo2, dout2);
        end
        v2 = 1'b1; w2 = 1'b1; addr2 = 6'd45; data2 = 15'h0000; mask2 = 15'h7FFF;
        @(posedge clk); #1;
        v2 = 1'b0;
        for (int a = 0; a < 40; a++) begin
            drive_read2(6'(a));
            tests++;
            if (vo2 !== 1'b1 || dout2 !== 15'h1234) begin
                failed++;
                $display("FAIL oob_write_side_effect addr=%0d: v_o=%b data_o=%h, expected 1 1234",
                         a, vo2, dout2);
            end
        end
        $display("[TB] els_p=40 out-of-range access checked");
    endtask

    task automatic test_reset_mid;
        int n;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (ready !== 1'b0 || vo !== 1'b0 || dout !== 15'h0) begin
            failed++;
            $display("FAIL reset_mid_sweep: ready=%b v_o=%b data_o=%h, expected 0 0 0000", ready, vo, dout);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n != 64) begin
            failed++;
            $display("FAIL resweep_length: ready_o rose after %0d cycles, expected 64", n);
        end
        drive_read(6'd5);
        tests++;
        if (vo !== 1'b1 || dout !== 15'h1234) begin
            failed++;
            $display("FAIL resweep_read: v_o=%b data_o=%h, expected 1 1234", vo, dout);
        end
        // Reset arrives while a read is accepted but before its edge.
        v = 1'b1; w = 1'b0; addr = 6'd7;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (ready !== 1'b0 || vo !== 1'b0 || dout !== 15'h0) begin
            failed++;
            $display("FAIL reset_mid_read: ready=%b v_o=%b data_o=%h, expected 0 0 0000", ready, vo, dout);
        end
        @(posedge clk); #1;
        v = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (vo !== 1'b0 || dout !== 15'h0) begin
            failed++;
            $display("FAIL read_lost: v_o=%b data_o=%h, expected 0 0000", vo, dout);
        end
        n = 1;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n != 64) begin
            failed++;
            $display("FAIL resweep2_length: ready_o rose after %0d cycles, expected 64", n);
        end
        $display("[TB] mid-operation reset checked");
    endtask

    initial begin
        rst_n = 1'b0; v = 1'b0; w = 1'b0; addr = '0; data = '0; mask = '0;
        rst2_n = 1'b0; v2 = 1'b0; w2 = 1'b0; addr2 = '0; data2 = '0; mask2 = '0;
        test_reset;
        test_init_sweep;
        test_masked_write;
        test_back_to_back;
        test_out_of_range;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bsg_mem_1rw_bit_mask_init.md
BSG_MEM_1RW_BIT_MASK_INIT -- requirements
Module: bsg_mem_1rw_bit_mask_init

Interface
REQ-001 Parameter width_p, default 15: data word width in bits; the legal range is 1 or more.
REQ-002 Parameter els_p, default 64: number of words; the legal range is 2 or more and need not be a power of two.
REQ-003 Parameter init_val_p, default 0: width_p-bit value written to every word by the post-reset sweep.
REQ-004 Parameter addr_width_lp, default $clog2(els_p): derived address width; it is not overridden.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset_n_i  input  1  asynchronous active-low reset.
REQ-008 v_i  input  1  access request valid.
REQ-009 w_i  input  1  1 = write, 0 = read; sampled with v_i.
REQ-010 addr_i  input  addr_width_lp  word address.
REQ-011 data_i  input  width_p  write data.
REQ-012 w_mask_i  input  width_p  per-bit write enable; 1 = bit written.
REQ-013 ready_o  output  1  block accepts an access this cycle.
REQ-014 init_done_o  output  1  post-reset sweep complete; stays high until the next reset.
REQ-015 v_o  output  1  data_o carries fresh read data this cycle.
REQ-016 data_o  output  width_p  registered read data.

Function
REQ-017 States: INIT and READY; reset forces INIT with the sweep counter at 0.
REQ-018 INIT: each cycle, write init_val_p with a full mask to address counter, then increment counter; after writing els_p-1, go to READY.
REQ-019 The sweep takes exactly els_p cycles; ready_o and init_done_o rise on the cycle after the last sweep write.
REQ-020 Handshake: an access is accepted only when v_i and ready_o are both 1; v_i while ready_o is 0 is dropped with no side effect.
REQ-021 ready_o = 1 in READY; ready_o is combinational from state only, never from v_i.
REQ-022 Accepted write: each bit i where w_mask_i[i] = 1 takes data_i[i]; other bits are unchanged; an all-zero mask is a legal no-op.
REQ-023 Accepted read: data_o = mem[addr_i] and v_o = 1 on the next cycle; latency is 1 cycle and throughput is 1 access per cycle.
REQ-024 v_o is 0 in every cycle not directly following an accepted read.
REQ-025 data_o holds the last read value until the next accepted read; writes, including to the last-read address, do not alter data_o.
REQ-026 Back-to-back read then write to the same address: data_o shows the pre-write value; a following read shows the post-write value.
REQ-027 addr_i >= els_p, when els_p is not a power of two: writes are discarded and reads return data_o = 0 with v_o = 1.
REQ-028 Reset asserted mid-operation: outputs go to their reset values immediately; any in-flight read is lost; the sweep restarts from 0 after release.

Reset
REQ-029 On reset: ready_o = 0, init_done_o = 0, v_o = 0, data_o = 0, state = INIT, counter = 0.
REQ-030 Storage array contents are not reset directly; they are defined only through the sweep.
REQ-031 Reset release is synchronised by the integrator; the block need not handle metastability.

Structure
REQ-032 Shared package bsg_mem_init_pkg holds the state enum typedef (INIT, READY).
REQ-033 The storage is a sub-module, bsg_mem_1rw_bit_mask_array: a synchronous 1rw array with a bit mask and no reset; it can later be swapped for a hardened macro.
REQ-034 The controller (FSM, counter, muxes on address/data/mask, output register) resides in the top module.

Verification
REQ-035 Reset release with width_p=15, els_p=64, init_val_p=0x1234: ready_o rises exactly 64 cycles later; reads of addresses 0..63 all return 0x1234 with v_o=1 one cycle after each read.
REQ-036 After init: write addr 5, data 0x7FFF, mask 0x00FF; then read addr 5 -> data_o = 0x12FF (init 0x1234 top bits preserved), v_o=1 one cycle later.
REQ-037 Read addr 5 (0x12FF), then write addr 5 with data 0 and mask 0x7FFF, then idle -> data_o stays 0x12FF; a re-read returns 0x0000.
REQ-038 v_i=1 held during INIT with writes of 0x7FFF to addr 0 -> no effect; addr 0 reads 0x1234 after init.
REQ-039 els_p=40: read addr 45 -> data_o=0, v_o=1; write addr 45 then read addrs 0..39 -> all words unchanged.
REQ-040 Assert reset_n_i 10 cycles into the sweep and during an accepted read -> ready_o, v_o and data_o are 0 immediately; a full els_p-cycle sweep reruns after release.
